// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared MIPS field positions, immediate-ext opcodes and fetch
//               state encoding for the fetch/extender slice.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI = 6'h0E;
    localparam logic [5:0] OP_LUI  = 6'h0F;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_MSB  = 10;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

    localparam logic [0:0] FETCH_REQ   = 1'b0;
    localparam logic [0:0] FETCH_DRAIN = 1'b1;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/ext_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : ext_ctrl_decode
// Description : Selects sign (1) or zero (0) extension of the 16-bit immediate.
// Revision    : 1.0 - initial release
// ============================================================================
module ext_ctrl_decode
    import mips_pkg::*;
(
    input  logic [5:0] i_opcode,
    output logic       o_sext
);

    // Only the logical immediates and LUI zero-extend; SLTIU still sign-extends.
    always_comb begin
        o_sext = 1'b1;
        case (i_opcode)
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: o_sext = 1'b0;
            default:                          o_sext = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_unit
// Description : PC + imem req/ack fetch with one-entry output register, redirect
//               drain, MIPS field slicing and immediate-extension control.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned PC_STEP  = 4
)(
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] pc_plus4,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] inst15_0,
    output logic        sext
);

    localparam logic [31:0] c_pc_step = 32'(PC_STEP);

    logic [0:0]  r_state;
    logic        r_pending;
    logic [31:0] r_req_addr;
    logic [31:0] r_pc;
    logic        r_inst_valid;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;

    logic        w_req;
    logic        w_ack;
    logic        w_outstanding;
    logic [31:0] w_addr;

    // A new fetch only issues into a free (or simultaneously consumed) slot.
    assign w_req         = !rst && (r_pending ||
                           (r_state == FETCH_REQ && (!r_inst_valid || !stall)));
    assign w_ack         = imem_ack && w_req;
    assign w_outstanding = w_req && !imem_ack;
    assign w_addr        = r_pending ? r_req_addr : r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= FETCH_REQ;
            r_pending    <= 1'b0;
            r_req_addr   <= 32'h0;
            r_pc         <= RESET_PC;
            r_inst_valid <= 1'b0;
            r_inst       <= 32'h0;
            r_inst_pc    <= 32'h0;
        end else begin
            if (w_ack) begin
                r_pending <= 1'b0;
            end else if (w_req) begin
                r_pending <= 1'b1;
            end
            if (w_req && !r_pending) begin
                r_req_addr <= r_pc;
            end

            // An unacked request must still be retired, so a redirect drains it.
            if (redirect_valid) begin
                r_pc         <= redirect_pc;
                r_inst_valid <= 1'b0;
                r_state      <= w_outstanding ? FETCH_DRAIN : FETCH_REQ;
            end else if (r_state == FETCH_DRAIN) begin
                if (w_ack) begin
                    r_state <= FETCH_REQ;
                end
            end else if (w_ack) begin
                r_inst       <= imem_rdata;
                r_inst_pc    <= w_addr;
                r_pc         <= w_addr + c_pc_step;
                r_inst_valid <= 1'b1;
            end else if (r_inst_valid && !stall) begin
                r_inst_valid <= 1'b0;
            end
        end
    end

    assign imem_req   = w_req;
    assign imem_addr  = w_addr;
    assign inst_valid = r_inst_valid;
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign pc_plus4   = r_inst_pc + c_pc_step;
    assign opcode     = r_inst[OPCODE_MSB:OPCODE_LSB];
    assign rs         = r_inst[RS_MSB:RS_LSB];
    assign rt         = r_inst[RT_MSB:RT_LSB];
    assign rd         = r_inst[RD_MSB:RD_LSB];
    assign shamt      = r_inst[SHAMT_MSB:SHAMT_LSB];
    assign funct      = r_inst[FUNCT_MSB:FUNCT_LSB];
    assign inst15_0   = r_inst[IMM_MSB:IMM_LSB];

    ext_ctrl_decode u_ext_ctrl_decode (
        .i_opcode (opcode),
        .o_sext   (sext)
    );

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch_unit
// Description : Directed self-checking bench for inst_fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] pc_plus4;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] inst15_0;
    logic        sext;

    int n_cmp = 0;
    int n_err = 0;

    inst_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .pc_plus4       (pc_plus4),
        .opcode         (opcode),
        .rs             (rs),
        .rt             (rt),
        .rd             (rd),
        .shamt          (shamt),
        .funct          (funct),
        .inst15_0       (inst15_0),
        .sext           (sext)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return 32'hA500_0000 ^ a;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after a rising edge; memory answers only if requested.
    task automatic drive(input logic s, input logic rv, input logic [31:0] rpc,
                         input logic ack_en, input logic [31:0] data);
        stall          = s;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        imem_ack   = ack_en & imem_req;
        imem_rdata = data;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_ack = 1'b0; imem_rdata = 32'h0;
        tick(); tick();
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", inst_valid); end
        n_cmp++; if (inst !== 32'h0) begin n_err++; $display("FAIL rst_inst: got %h want 0", inst); end
        n_cmp++; if (inst_pc !== 32'h0) begin n_err++; $display("FAIL rst_inst_pc: got %h want 0", inst_pc); end
        n_cmp++; if (opcode !== 6'h0 || inst15_0 !== 16'h0) begin n_err++; $display("FAIL rst_fields: got op %h imm %h want 0", opcode, inst15_0); end
        n_cmp++; if (sext !== 1'b1) begin n_err++; $display("FAIL rst_sext: got %b want 1", sext); end
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", imem_req); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
        rst = 1'b0;
    endtask

    task automatic test_zero_wait();
        for (int k = 0; k < 4; k++) begin
            logic [31:0] a;
            a = 32'(k * 4);
            drive(1'b0, 1'b0, 32'h0, 1'b1, memw(a));
            n_cmp++; if (imem_req !== 1'b1 || imem_addr !== a) begin n_err++; $display("FAIL zw_issue[%0d]: got req %b addr %h want 1 %h", k, imem_req, imem_addr, a); end
            tick();
            n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== a || inst !== memw(a)) begin n_err++; $display("FAIL zw_load[%0d]: got v %b pc %h inst %h want 1 %h %h", k, inst_valid, inst_pc, inst, a, memw(a)); end
            n_cmp++; if (pc_plus4 !== a + 32'd4) begin n_err++; $display("FAIL zw_pc4[%0d]: got %h want %h", k, pc_plus4, a + 32'd4); end
        end
    endtask

    task automatic test_stall();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
            n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL stall_req[%0d]: got %b want 0", k, imem_req); end
            tick();
            n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'hC || inst !== memw(32'hC)) begin n_err++; $display("FAIL stall_hold[%0d]: got v %b pc %h inst %h want 1 0000000c %h", k, inst_valid, inst_pc, inst, memw(32'hC)); end
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1, memw(32'h10));
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin n_err++; $display("FAIL stall_release: got req %b addr %h want 1 00000010", imem_req, imem_addr); end
        tick();
        n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h10) begin n_err++; $display("FAIL stall_next: got v %b pc %h want 1 00000010", inst_valid, inst_pc); end
    endtask

    task automatic test_latency();
        // Stall on the middle cycle: the pending request must still be held.
        logic [2:0] st;
        st = 3'b010;
        for (int k = 0; k < 3; k++) begin
            drive(st[k], 1'b0, 32'h0, (k == 2), memw(32'h14));
            n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin n_err++; $display("FAIL lat_hold[%0d]: got req %b addr %h want 1 00000014", k, imem_req, imem_addr); end
            tick();
            n_cmp++; if (inst_valid !== (k == 2)) begin n_err++; $display("FAIL lat_valid[%0d]: got %b want %b", k, inst_valid, (k == 2)); end
        end
        n_cmp++; if (inst_pc !== 32'h14 || inst !== memw(32'h14)) begin n_err++; $display("FAIL lat_load: got pc %h inst %h want 00000014 %h", inst_pc, inst, memw(32'h14)); end
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL lat_once_req: got %b want 0", imem_req); end
        tick();
        n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h14) begin n_err++; $display("FAIL lat_once: got v %b pc %h want 1 00000014", inst_valid, inst_pc); end
    endtask

    task automatic test_redirect_drain();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b1, 32'h100, 1'b0, 32'h0);
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h18) begin n_err++; $display("FAIL drn_pend: got req %b addr %h want 1 00000018", imem_req, imem_addr); end
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        n_cmp++; if (dut.r_state !== 1'b1) begin n_err++; $display("FAIL drn_state: got %b want 1", dut.r_state); end
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h18) begin n_err++; $display("FAIL drn_hold: got req %b addr %h want 1 00000018", imem_req, imem_addr); end
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1, memw(32'h18));
        tick();
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL drn_discard: got %b want 0", inst_valid); end
        drive(1'b0, 1'b0, 32'h0, 1'b1, memw(32'h100));
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_err++; $display("FAIL drn_target: got req %b addr %h want 1 00000100", imem_req, imem_addr); end
        tick();
        n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst !== memw(32'h100)) begin n_err++; $display("FAIL drn_load: got v %b pc %h inst %h want 1 00000100 %h", inst_valid, inst_pc, inst, memw(32'h100)); end
    endtask

    task automatic test_redirect_ack();
        drive(1'b0, 1'b1, 32'h200, 1'b1, memw(32'h104));
        n_cmp++; if (imem_addr !== 32'h104) begin n_err++; $display("FAIL rack_addr: got %h want 00000104", imem_addr); end
        tick();
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rack_drop: got %b want 0", inst_valid); end
        drive(1'b0, 1'b0, 32'h0, 1'b1, memw(32'h200));
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin n_err++; $display("FAIL rack_next: got req %b addr %h want 1 00000200", imem_req, imem_addr); end
        tick();
        n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h200 || pc_plus4 !== 32'h204) begin n_err++; $display("FAIL rack_load: got v %b pc %h pc4 %h want 1 00000200 00000204", inst_valid, inst_pc, pc_plus4); end
    endtask

    task automatic test_fields();
        logic [31:0] w   [5] = '{32'h3421_FFFF, 32'h2421_FFFF, 32'h3C01_8000, 32'h2C21_8000, 32'h012A_4822};
        logic [5:0]  eop [5] = '{6'h0D, 6'h09, 6'h0F, 6'h0B, 6'h00};
        logic [4:0]  ers [5] = '{5'd1, 5'd1, 5'd0, 5'd1, 5'd9};
        logic [4:0]  ert [5] = '{5'd1, 5'd1, 5'd1, 5'd1, 5'd10};
        logic [4:0]  erd [5] = '{5'h1F, 5'h1F, 5'h10, 5'h10, 5'd9};
        logic [4:0]  esh [5] = '{5'h1F, 5'h1F, 5'h00, 5'h00, 5'h00};
        logic [5:0]  efn [5] = '{6'h3F, 6'h3F, 6'h00, 6'h00, 6'h22};
        logic [15:0] eim [5] = '{16'hFFFF, 16'hFFFF, 16'h8000, 16'h8000, 16'h4822};
        logic        esx [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b1, w[k]);
            tick();
            n_cmp++; if (inst_pc !== 32'h204 + 32'(4 * k) || opcode !== eop[k] || funct !== efn[k]) begin n_err++; $display("FAIL fld_op[%0d]: got pc %h op %h fn %h want %h %h %h", k, inst_pc, opcode, funct, 32'h204 + 32'(4 * k), eop[k], efn[k]); end
            n_cmp++; if (rs !== ers[k] || rt !== ert[k] || rd !== erd[k] || shamt !== esh[k]) begin n_err++; $display("FAIL fld_regs[%0d]: got %h %h %h %h want %h %h %h %h", k, rs, rt, rd, shamt, ers[k], ert[k], erd[k], esh[k]); end
            n_cmp++; if (inst15_0 !== eim[k] || sext !== esx[k]) begin n_err++; $display("FAIL fld_ext[%0d]: got imm %h sext %b want %h %b", k, inst15_0, sext, eim[k], esx[k]); end
        end
    endtask

    task automatic test_wrap();
        drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h1234_5678);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1, memw(32'hFFFF_FFFC));
        n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_issue: got %h want fffffffc", imem_addr); end
        tick();
        n_cmp++; if (inst_pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin n_err++; $display("FAIL wrap_pc4: got pc %h pc4 %h want fffffffc 00000000", inst_pc, pc_plus4); end
        drive(1'b0, 1'b0, 32'h0, 1'b1, memw(32'h0));
        n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL wrap_addr: got %h want 0", imem_addr); end
        tick();
        n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin n_err++; $display("FAIL wrap_load: got v %b pc %h want 1 0", inst_valid, inst_pc); end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF);
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rmid_req: got %b want 0", imem_req); end
        tick();
        n_cmp++; if (inst_valid !== 1'b0 || imem_addr !== 32'h0 || inst_pc !== 32'h0) begin n_err++; $display("FAIL rmid_state: got v %b addr %h pc %h want 0 0 0", inst_valid, imem_addr, inst_pc); end
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b1, memw(32'h0));
        tick();
        n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== memw(32'h0)) begin n_err++; $display("FAIL rmid_restart: got v %b pc %h inst %h want 1 0 %h", inst_valid, inst_pc, inst, memw(32'h0)); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_stall();
        test_latency();
        test_redirect_drain();
        test_redirect_ack();
        test_fields();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
